// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU request sequencer.
package alu_seq_pkg;

  localparam int OPW  = 4;
  localparam int YW   = 5;
  localparam int CNTW = 8;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [1:0]     op;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           id;
  } req_t;

endpackage

// File: rtl/alu_req_sequencer_if.sv
// Request/response bus between requesters and the ALU sequencer.
interface alu_req_sequencer_if;
  import alu_seq_pkg::*;

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_op0;
  logic [1:0]      req_op1;
  logic [OPW-1:0]  req_a0;
  logic [OPW-1:0]  req_b0;
  logic [OPW-1:0]  req_a1;
  logic [OPW-1:0]  req_b1;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [YW-1:0]   rsp_y;
  logic            rsp_ovf;
  logic            ovf_sticky;
  logic [CNTW-1:0] ovf_count;
  logic            ovf_clr;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
           rsp_ready, ovf_clr,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_ovf, ovf_sticky, ovf_count
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
           rsp_ready, ovf_clr,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_ovf, ovf_sticky, ovf_count
  );

endinterface

// File: rtl/alu4_ovf.sv
// Combinational 4-bit ALU with signed-overflow detection (wrapped result only).
module alu4_ovf
  import alu_seq_pkg::*;
(
  input  logic [1:0]     op,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [YW-1:0]  y,
  output logic           ovf
);

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_AND: y = {1'b0, a & b};
      OP_ADD: begin
        y   = {1'b0, a} + {1'b0, b};
        ovf = (a[OPW-1] == b[OPW-1]) && (y[OPW-1] != a[OPW-1]);
      end
      OP_SUB: begin
        // bit 4 ends up as the inverted borrow of a + ~b + 1
        y   = {1'b0, a} + {1'b0, ~b} + 5'd1;
        ovf = (a[OPW-1] != b[OPW-1]) && (y[OPW-1] != a[OPW-1]);
      end
      default: y = {1'b0, a | b};
    endcase
  end

endmodule

// File: rtl/alu_req_sequencer.sv
// Two-port round-robin sequencer around one shared ALU, with overflow status.
// ALU_SAT_EN: saturate ADD/SUB results on signed overflow.
module alu_req_sequencer
  import alu_seq_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  alu_req_sequencer_if.slave bus
);

  state_t          state;
  logic            ptr;
  req_t            cur;
  logic [1:0]      grant;
  logic [YW-1:0]   aluY;
  logic            aluOvf;
  logic [YW-1:0]   resY;
  logic            rspValid;
  logic            rspId;
  logic [YW-1:0]   rspY;
  logic            rspOvf;
  logic            ovfSticky;
  logic [CNTW-1:0] ovfCount;

  logic [1:0][1:0]     portOp;
  logic [1:0][OPW-1:0] portA;
  logic [1:0][OPW-1:0] portB;

  assign portOp = {bus.req_op1, bus.req_op0};
  assign portA  = {bus.req_a1,  bus.req_a0};
  assign portB  = {bus.req_b1,  bus.req_b0};

  always_comb begin
    case (bus.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // rst_n gate keeps ready low while reset is asserted even though state reads IDLE
  assign bus.req_ready = (rst_n && state == IDLE) ? grant : 2'b00;

  alu4_ovf uAlu (
    .op  (cur.op),
    .a   (cur.a),
    .b   (cur.b),
    .y   (aluY),
    .ovf (aluOvf)
  );

`ifdef ALU_SAT_EN
  always_comb begin
    resY = aluY;
    if (aluOvf) resY = cur.a[OPW-1] ? 5'h08 : 5'h07;
  end
`else
  assign resY = aluY;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cur       <= '0;
      rspValid  <= 1'b0;
      rspId     <= 1'b0;
      rspY      <= '0;
      rspOvf    <= 1'b0;
      ovfSticky <= 1'b0;
      ovfCount  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            cur.id <= grant[1];
            cur.op <= portOp[grant[1]];
            cur.a  <= portA[grant[1]];
            cur.b  <= portB[grant[1]];
            ptr    <= ~grant[1];
            state  <= EXEC;
          end
        end
        EXEC: begin
          rspY     <= resY;
          rspOvf   <= aluOvf;
          rspId    <= cur.id;
          rspValid <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (bus.ovf_clr) begin
        ovfSticky <= 1'b0;
        ovfCount  <= '0;
      end else if (state == EXEC && aluOvf) begin
        ovfSticky <= 1'b1;
        if (ovfCount != '1) ovfCount <= ovfCount + 1'b1;
      end
    end
  end

  assign bus.rsp_valid  = rspValid;
  assign bus.rsp_id     = rspId;
  assign bus.rsp_y      = rspY;
  assign bus.rsp_ovf    = rspOvf;
  assign bus.ovf_sticky = ovfSticky;
  assign bus.ovf_count  = ovfCount;

endmodule
